// File: rtl/pdp1_terminal_glyph_fetch_pkg.sv
// Shared constants for the PDP-1 terminal glyph fetch path: glyph geometry,
// ROM address split and fetch FSM state encoding.
package pdp1_terminal_pkg;

  localparam int GLYPH_W  = 16;
  localparam int ROW_BITS = 4;
  localparam int ADDR_W   = 12;
  localparam int CODE_W   = ADDR_W - ROW_BITS;
  localparam int CNT_W    = $clog2(GLYPH_W + 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_FULL = 2'd2;

  // The character code selects the glyph and the row indexes within it.
  function automatic logic [ADDR_W-1:0] glyph_addr(input logic [CODE_W-1:0] code,
                                                   input logic [ROW_BITS-1:0] row);
    return {code, row};
  endfunction

endpackage

// File: rtl/pdp1_terminal_glyph_fetch_if.sv
// Character request channel: a (code, row) pair offered with valid/ready.
interface pdp1_terminal_glyph_fetch_if;
  import pdp1_terminal_pkg::*;

  logic                char_valid;
  logic                char_ready;
  logic [CODE_W-1:0]   char_code;
  logic [ROW_BITS-1:0] char_row;

  modport master (
    output char_valid,
    output char_code,
    output char_row,
    input  char_ready
  );

  modport slave (
    input  char_valid,
    input  char_code,
    input  char_row,
    output char_ready
  );

endinterface

// File: rtl/pdp1_terminal_glyph_fetch_shifter.sv
// Pixel serialiser: loads a glyph row from the prefetch buffer and shifts it
// out MSB-first, one pixel per pixel_en.
module pdp1_glyph_shifter
  import pdp1_terminal_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               buffer_full,
  input  logic [GLYPH_W-1:0] buffer_data,
  input  logic               pixel_en,
  output logic               load,
  output logic               pixel_out,
  output logic               pixel_valid,
  output logic               glyph_start,
  output logic               underrun
);

  logic [GLYPH_W-1:0] shreg;
  logic [CNT_W-1:0]   count;

  // Reloading while the last pixel is consumed keeps consecutive rows gapless.
  assign load = buffer_full &&
                ((count == '0) || ((count == CNT_W'(1)) && pixel_en));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      shreg <= '0;
      count <= '0;
    end else if (load) begin
      shreg <= buffer_data;
      count <= CNT_W'(GLYPH_W);
    end else if (pixel_en && (count != '0)) begin
      shreg <= {shreg[GLYPH_W-2:0], 1'b0};
      count <= count - CNT_W'(1);
    end
  end

  assign pixel_valid = (count != '0);
  assign pixel_out   = pixel_valid && shreg[GLYPH_W-1];
  assign glyph_start = load;
  assign underrun    = pixel_en && (count == '0) && !load;

endmodule

// File: rtl/pdp1_terminal_glyph_fetch.sv
// FIO-DEC character ROM sequencer: accepts (code, row) requests, waits out the
// ROM latency, prefetches one glyph row and hands it to the pixel shifter.
module pdp1_terminal_glyph_fetch
  import pdp1_terminal_pkg::*;
#(
  parameter int ROM_LATENCY = 1
) (
  input  logic                clock,
  input  logic                reset_n,
  pdp1_terminal_glyph_fetch_if.slave req,
  output logic [ADDR_W-1:0]   rom_address,
  input  logic [GLYPH_W-1:0]  rom_q,
  input  logic                pixel_en,
  output logic                pixel_out,
  output logic                pixel_valid,
  output logic                glyph_start,
  output logic                underrun
);

  localparam logic [1:0] LATENCY_LOAD = 2'(ROM_LATENCY);

  logic [1:0]         state;
  logic [1:0]         wait_cnt;
  logic [GLYPH_W-1:0] buffer;
  logic               load;

  assign req.char_ready = (state == ST_IDLE);

  // The counter reaches zero one edge before the capture, so capture lands
  // ROM_LATENCY + 1 edges after the accept edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      wait_cnt    <= '0;
      rom_address <= '0;
      buffer      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req.char_valid) begin
            rom_address <= glyph_addr(req.char_code, req.char_row);
            wait_cnt    <= LATENCY_LOAD;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (wait_cnt == '0) begin
            buffer <= rom_q;
            state  <= ST_FULL;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        ST_FULL: begin
          if (load) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pdp1_glyph_shifter u_shifter (
    .clock       (clock),
    .reset_n     (reset_n),
    .buffer_full (state == ST_FULL),
    .buffer_data (buffer),
    .pixel_en    (pixel_en),
    .load        (load),
    .pixel_out   (pixel_out),
    .pixel_valid (pixel_valid),
    .glyph_start (glyph_start),
    .underrun    (underrun)
  );

endmodule

// File: tb/tb_pdp1_terminal_glyph_fetch.sv
// Directed bench for the glyph fetch path: one instance at ROM latency 1 with a
// registered ROM model, one at latency 3 with rom_q driven by hand.
module tb_pdp1_terminal_glyph_fetch;

  logic        clock;
  logic        reset_n;

  logic [11:0] rom_address1;
  logic [15:0] rom_q1;
  logic        pixel_en1, pixel_out1, pixel_valid1, glyph_start1, underrun1;

  logic [11:0] rom_address3;
  logic [15:0] rom_q3;
  logic        pixel_en3, pixel_out3, pixel_valid3, glyph_start3, underrun3;

  int checks;
  int errors;

  pdp1_terminal_glyph_fetch_if req1 ();
  pdp1_terminal_glyph_fetch_if req3 ();

  pdp1_terminal_glyph_fetch #(.ROM_LATENCY(1)) dut1 (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req1),
    .rom_address (rom_address1),
    .rom_q       (rom_q1),
    .pixel_en    (pixel_en1),
    .pixel_out   (pixel_out1),
    .pixel_valid (pixel_valid1),
    .glyph_start (glyph_start1),
    .underrun    (underrun1)
  );

  pdp1_terminal_glyph_fetch #(.ROM_LATENCY(3)) dut3 (
    .clock       (clock),
    .reset_n     (reset_n),
    .req         (req3),
    .rom_address (rom_address3),
    .rom_q       (rom_q3),
    .pixel_en    (pixel_en3),
    .pixel_out   (pixel_out3),
    .pixel_valid (pixel_valid3),
    .glyph_start (glyph_start3),
    .underrun    (underrun3)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Character ROM contents used by the latency-1 instance.
  function automatic logic [15:0] rom_lookup(input logic [11:0] a);
    case (a)
      12'h215: return 16'hA5C3;
      12'h300: return 16'hFFFF;
      12'h301: return 16'h0001;
      12'h400: return 16'h8000;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clock) rom_q1 <= rom_lookup(rom_address1);

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic mid();
    @(negedge clock);
  endtask

  task automatic apply_stimulus(input logic valid, input logic [7:0] code, input logic [3:0] row);
    req1.char_valid = valid;
    req1.char_code  = code;
    req1.char_row   = row;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      $error("[TB] check %s did not match", tag);
    end
  endtask

  initial begin
    logic [15:0] word;
    logic [31:0] stream;
    int nvalid;
    int first_start, second_start, accepted_at, first_valid, last_valid, valid_cycles, ready_bad;
    logic ready_after;
    logic seen;

    checks = 0;
    errors = 0;
    reset_n = 1'b0;
    apply_stimulus(1'b0, 8'h00, 4'h0);
    pixel_en1 = 1'b0;
    req3.char_valid = 1'b0;
    req3.char_code  = 8'h00;
    req3.char_row   = 4'h0;
    pixel_en3 = 1'b0;
    rom_q3 = 16'h0000;

    // Reset values
    step();
    step();
    mid();
    check_output("reset_ready",       32'(req1.char_ready), 32'd1);
    check_output("reset_rom_address", 32'(rom_address1), 32'h000);
    check_output("reset_pixel_valid", 32'(pixel_valid1), 32'd0);
    check_output("reset_pixel_out",   32'(pixel_out1), 32'd0);
    check_output("reset_glyph_start", 32'(glyph_start1), 32'd0);
    check_output("reset_underrun",    32'(underrun1), 32'd0);
    check_output("reset_ready_lat3",  32'(req3.char_ready), 32'd1);
    step();
    reset_n = 1'b1;

    // Underrun with no request outstanding
    pixel_en1 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      mid();
      check_output("underrun_pulse", 32'({underrun1, pixel_out1, req1.char_ready}), 32'b101);
      step();
    end
    pixel_en1 = 1'b0;

    // Single fetch, latency 1
    apply_stimulus(1'b1, 8'h21, 4'd5);
    pixel_en1 = 1'b1;
    step();
    apply_stimulus(1'b0, 8'h00, 4'h0);
    mid();
    check_output("single_rom_address", 32'(rom_address1), 32'h215);
    check_output("single_ready_low",   32'(req1.char_ready), 32'd0);
    check_output("single_no_start_c0", 32'(glyph_start1), 32'd0);
    step();
    mid();
    check_output("single_no_start_c1", 32'(glyph_start1), 32'd0);
    step();
    mid();
    check_output("single_glyph_start", 32'(glyph_start1), 32'd1);
    step();
    word = '0;
    nvalid = 0;
    for (int k = 0; k < 16; k++) begin
      mid();
      word = {word[14:0], pixel_out1};
      if (pixel_valid1) nvalid++;
      step();
    end
    check_output("single_pixels",      32'(word), 32'hA5C3);
    check_output("single_valid_count", 32'(nvalid), 32'd16);
    mid();
    check_output("single_drained", 32'(pixel_valid1), 32'd0);
    pixel_en1 = 1'b0;
    step();

    // Back-to-back rows with continuous pixel_en
    apply_stimulus(1'b1, 8'h30, 4'd0);
    pixel_en1 = 1'b1;
    step();
    apply_stimulus(1'b1, 8'h30, 4'd1);
    first_start = -1; second_start = -1; accepted_at = -1;
    first_valid = -1; last_valid = -1; valid_cycles = 0; ready_bad = 0;
    ready_after = 1'b0;
    stream = '0;
    for (int c = 0; c < 40; c++) begin
      mid();
      if (glyph_start1) begin
        if (first_start < 0) first_start = c;
        else if (second_start < 0) second_start = c;
      end
      if (pixel_valid1) begin
        if (first_valid < 0) first_valid = c;
        last_valid = c;
        valid_cycles++;
        stream = {stream[30:0], pixel_out1};
      end
      if (accepted_at >= 0 && (second_start < 0 || c == second_start) && req1.char_ready) ready_bad++;
      if (second_start >= 0 && c == second_start + 1) ready_after = req1.char_ready;
      if (req1.char_valid && req1.char_ready) accepted_at = c;
      step();
      if (accepted_at == c) apply_stimulus(1'b0, 8'h00, 4'h0);
    end
    pixel_en1 = 1'b0;
    check_output("b2b_first_start",  32'(first_start), 32'd2);
    check_output("b2b_start_gap",    32'(second_start - first_start), 32'd16);
    check_output("b2b_second_accept", 32'(accepted_at), 32'd3);
    check_output("b2b_valid_cycles", 32'(valid_cycles), 32'd32);
    check_output("b2b_valid_span",   32'(last_valid - first_valid), 32'd31);
    check_output("b2b_stream",       stream, 32'hFFFF_0001);
    check_output("b2b_ready_low",    32'(ready_bad), 32'd0);
    check_output("b2b_ready_return", 32'(ready_after), 32'd1);

    // Stalled pixel_en holds the loaded row
    apply_stimulus(1'b1, 8'h40, 4'd0);
    step();
    apply_stimulus(1'b0, 8'h00, 4'h0);
    step();
    step();
    mid();
    check_output("stall_glyph_start", 32'(glyph_start1), 32'd1);
    step();
    for (int i = 0; i < 10; i++) begin
      mid();
      check_output("stall_hold", 32'({pixel_valid1, pixel_out1}), 32'b11);
      step();
    end
    pixel_en1 = 1'b1;
    word = '0;
    nvalid = 0;
    for (int k = 0; k < 16; k++) begin
      mid();
      word = {word[14:0], pixel_out1};
      if (pixel_valid1) nvalid++;
      step();
    end
    check_output("stall_pixels",      32'(word), 32'h8000);
    check_output("stall_valid_count", 32'(nvalid), 32'd16);
    mid();
    check_output("stall_drained", 32'(pixel_valid1), 32'd0);
    pixel_en1 = 1'b0;
    step();

    // Latency 3: only the rom_q present at accept + 4 edges is captured
    req3.char_valid = 1'b1;
    req3.char_code  = 8'h12;
    req3.char_row   = 4'd3;
    rom_q3 = 16'h1111;
    step();
    req3.char_valid = 1'b0;
    mid();
    check_output("lat3_rom_address", 32'(rom_address3), 32'h123);
    check_output("lat3_no_start_c0", 32'(glyph_start3), 32'd0);
    rom_q3 = 16'hDEAD;
    step();
    mid();
    check_output("lat3_no_start_c1", 32'(glyph_start3), 32'd0);
    rom_q3 = 16'hBEEF;
    step();
    mid();
    check_output("lat3_no_start_c2", 32'(glyph_start3), 32'd0);
    rom_q3 = 16'h5A5A;
    step();
    mid();
    check_output("lat3_no_start_c3", 32'(glyph_start3), 32'd0);
    rom_q3 = 16'hC3C3;
    step();
    mid();
    check_output("lat3_glyph_start", 32'(glyph_start3), 32'd1);
    check_output("lat3_ready_low",   32'(req3.char_ready), 32'd0);
    rom_q3 = 16'h0000;
    step();
    pixel_en3 = 1'b1;
    word = '0;
    for (int k = 0; k < 16; k++) begin
      mid();
      word = {word[14:0], pixel_out3};
      step();
    end
    check_output("lat3_pixels", 32'(word), 32'hC3C3);
    mid();
    check_output("lat3_drained", 32'(pixel_valid3), 32'd0);
    pixel_en3 = 1'b0;
    step();

    // Reset during WAIT discards the fetch
    apply_stimulus(1'b1, 8'h21, 4'd5);
    step();
    apply_stimulus(1'b0, 8'h00, 4'h0);
    #2;
    reset_n = 1'b0;
    #1;
    check_output("rst_wait_ready",       32'(req1.char_ready), 32'd1);
    check_output("rst_wait_rom_address", 32'(rom_address1), 32'h000);
    step();
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      seen = seen | glyph_start1 | pixel_valid1;
      step();
    end
    check_output("rst_wait_no_start", 32'(seen), 32'd0);

    // Reset after 7 pixels discards the partial row
    apply_stimulus(1'b1, 8'h21, 4'd5);
    step();
    apply_stimulus(1'b0, 8'h00, 4'h0);
    step();
    step();
    step();
    pixel_en1 = 1'b1;
    for (int i = 0; i < 7; i++) step();
    pixel_en1 = 1'b0;
    mid();
    check_output("mid_shift_pixel", 32'({pixel_valid1, pixel_out1}), 32'b11);
    #1;
    reset_n = 1'b0;
    #1;
    check_output("rst_shift_outputs",
                 32'({pixel_valid1, pixel_out1, glyph_start1, underrun1, req1.char_ready}), 32'b00001);
    check_output("rst_shift_rom_address", 32'(rom_address1), 32'h000);
    step();
    reset_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mid();
      seen = seen | glyph_start1 | pixel_valid1;
      step();
    end
    check_output("rst_shift_no_start", 32'(seen), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pdp1_terminal_glyph_fetch.md
Name: pdp1_terminal_glyph_fetch

Overview:
- Sequences the FIO-DEC character-set ROM for the terminal/typewriter display.
- Accepts (character, row) requests through a valid/ready handshake and issues the ROM address.
- Captures the 16-bit glyph row after the ROM read latency into a one-entry prefetch buffer.
- Serialises the row MSB-first to the pixel pipeline on a pixel enable, so the next fetch overlaps the current shift-out.

Parameters:
- ROM_LATENCY, 1, clock edges from rom_address change to valid rom_q (registered ROM = 1); legal range 1..3.
- GLYPH_W, 16, pixels per glyph row (ROM word width).
- ROW_BITS, 4, row index width; the character code gets 12-ROW_BITS bits.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  reset, asynchronous assert, active-low.
- char_valid  in  1  request valid.
- char_ready  out  1  request accepted when char_valid && char_ready.
- char_code  in  8  character index, FIO-DEC code plus case bit.
- char_row  in  4  glyph row 0..15.
- rom_address  out  12  ROM address, {char_code, char_row}.
- rom_q  in  16  ROM data.
- pixel_en  in  1  one pixel consumed this cycle.
- pixel_out  out  1  current pixel, MSB of the shifter.
- pixel_valid  out  1  shifter holds at least one pixel.
- glyph_start  out  1  one-cycle pulse when a new row is loaded into the shifter.
- underrun  out  1  one-cycle pulse when pixel_en arrives with the shifter empty.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (reset_n).
- Reset values:
  - All outputs 0 except char_ready = 1.
  - rom_address = 0.
  - FSM in IDLE; buffer empty; shifter count = 0.
- Fetch FSM, three states:
  - IDLE: char_ready = 1.
    - On accept, register rom_address = {char_code, char_row}, load wait counter = ROM_LATENCY, go to WAIT.
  - WAIT: char_ready = 0.
    - Decrement the counter each cycle.
    - On the cycle it reaches 0, capture rom_q into the buffer and go to FULL.
    - With ROM_LATENCY = 1: accept at edge t, capture at edge t+2.
  - FULL: char_ready = 0. Leave FULL on the edge where the buffer transfers to the shifter.
    - Go to IDLE.
    - char_ready rises the following cycle; there is no combinational ready path.
- rom_address holds its value outside accept edges.
- Shifter (GLYPH_W bits plus a 5-bit count):
  - Load condition: buffer FULL and (count == 0, or count == 1 with pixel_en).
  - On load: shifter = buffer, count = GLYPH_W, glyph_start = 1 for one cycle.
  - Back-to-back rows therefore have no bubble.
  - pixel_en with count > 0 (and no load): shift left 1, count - 1.
  - pixel_out = shifter[GLYPH_W-1] when count > 0, else 0.
  - pixel_valid = (count != 0).
- Underrun: pixel_en with count == 0 and no load that cycle → underrun = 1 for one cycle; pixel_out stays 0; state unchanged.
- Simultaneous events:
  - The capture into the buffer and a load from the buffer cannot collide: capture only happens in WAIT, load only from FULL.
  - Accept in IDLE may coincide with shifting; they are independent.
- Reset mid-operation: asserting reset_n low at any time returns all state to reset values immediately.
  - An in-flight fetch is discarded.
  - A partially shifted row is discarded.
- Width rules:
  - The address concatenation is exact; no arithmetic.
  - Count compares are unsigned.

Decomposition:
- Shared package pdp1_terminal_pkg:
  - GLYPH_W and ROW_BITS.
  - Fetch state encoding ST_IDLE/ST_WAIT/ST_FULL.
- Sub-module pdp1_glyph_shifter: shift register, count, glyph_start and underrun logic.
- The parent holds the handshake, FSM, address register and buffer.

Test Plan:
- Single fetch, ROM_LATENCY = 1:
  - Stimulus: char_code = 8'h21, char_row = 4'd5, ROM word 16'hA5C3 at 12'h215, pixel_en held high.
  - Required: rom_address = 12'h215 one edge after accept.
  - Required: glyph_start pulses at accept + 2 edges.
  - Required: pixel_out sequence 1010_0101_1100_0011, then pixel_valid = 0.
- Back-to-back:
  - Stimulus: rows 16'hFFFF then 16'h0001 requested while pixel_en is continuous.
  - Required: 32 consecutive pixel_valid cycles with no gap.
  - Required: second glyph_start exactly 16 pixels after the first.
  - Required: char_ready low from accept until the buffer drains.
- Underrun:
  - Stimulus: pixel_en = 1 for 3 cycles after reset with no request.
  - Required: underrun = 1 on each of those 3 cycles; pixel_out = 0; char_ready stays 1.
- Stalled pixel_en:
  - Stimulus: load 16'h8000 with pixel_en = 0 for 10 cycles, then 1.
  - Required: count stays 16; pixel_out = 1 on the first enabled pixel, then 0.
- ROM_LATENCY = 3:
  - Required: capture occurs at accept + 4 edges; rom_q changes before that edge are ignored.
- Reset mid-fetch and mid-shift:
  - Stimulus: drop reset_n during WAIT and again after 7 pixels shifted.
  - Required: outputs return to reset values asynchronously.
  - Required: no glyph_start is produced for the discarded fetch after reset release.
